draw_sprite: RTL

DRAW_SPRITE -- requirements
Module: draw_sprite

---
 rtl/vga_pkg.sv | 15 +
 rtl/draw_pipe_delay.sv | 23 ++
 rtl/draw_sprite.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and the sprite-draw FSM state type.
package vga_pkg;
  localparam int SCR_W_DEF  = 160;
  localparam int SCR_H_DEF  = 120;
  localparam int VGA_X_W    = 8;
  localparam int VGA_Y_W    = 7;
  localparam int ROM_ADDR_W = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/draw_pipe_delay.sv
// Fixed-depth register delay line; keeps pixel coordinates in step with ROM read latency.
module draw_pipe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/draw_sprite.sv
// Raster-scans an external image ROM and plots it at (pos_x,pos_y) with screen clipping.
// Define DRAW_SPRITE_TRANSPARENCY_EN to skip pixels whose colour equals TRANSP_KEY.
module draw_sprite import vga_pkg::*; #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCR_W    = SCR_W_DEF,
  parameter int SCR_H    = SCR_H_DEF,
  parameter int COLOUR_W = 3,
  parameter int ROM_LAT  = 1,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY = '0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [VGA_X_W-1:0]    pos_x,
  input  logic [VGA_Y_W-1:0]    pos_y,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [COLOUR_W-1:0]   rom_q,
  output logic [VGA_X_W-1:0]    vga_x,
  output logic [VGA_Y_W-1:0]    vga_y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  done
);
  localparam logic [ROM_ADDR_W-1:0] LAST_ADDR  = ROM_ADDR_W'(IMG_W*IMG_H-1);
  localparam logic [VGA_X_W-1:0]    LAST_COL   = VGA_X_W'(IMG_W-1);
  localparam logic [2:0]            LAST_DRAIN = 3'(ROM_LAT-1);
  localparam int                    PW         = 1 + VGA_X_W + VGA_Y_W;

  state_t                  r_state, w_next;
  logic [VGA_X_W-1:0]      r_px, r_col, w_col;
  logic [VGA_Y_W-1:0]      r_py, r_row, w_row;
  logic [ROM_ADDR_W-1:0]   r_addr;
  logic [2:0]              r_drain;
  logic                    w_vld, w_on, w_opaque;
  logic [VGA_X_W:0]        w_sx;
  logic [VGA_Y_W:0]        w_sy;

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (r_addr == LAST_ADDR) w_next = S_DRAIN;
      S_DRAIN: if (r_drain == LAST_DRAIN) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Linear address counter runs alongside col/row; both stop on the last pixel.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_px    <= '0;
      r_py    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_px   <= pos_x;
          r_py   <= pos_y;
          r_col  <= '0;
          r_row  <= '0;
          r_addr <= '0;
        end
        S_FETCH: begin
          r_drain <= '0;
          if (r_addr != LAST_ADDR) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DRAIN: r_drain <= r_drain + 1'b1;
        default: ;
      endcase
    end
  end

  draw_pipe_delay #(.DEPTH(ROM_LAT), .WIDTH(PW)) u_delay (
    .clock  (clock),
    .resetn (resetn),
    .i_d    ({r_state == S_FETCH, r_col, r_row}),
    .o_q    ({w_vld, w_col, w_row})
  );

  assign w_sx = {1'b0, r_px} + {1'b0, w_col};
  assign w_sy = {1'b0, r_py} + {1'b0, w_row};
  assign w_on = w_vld && (w_sx < (VGA_X_W+1)'(SCR_W)) && (w_sy < (VGA_Y_W+1)'(SCR_H));

`ifdef DRAW_SPRITE_TRANSPARENCY_EN
  assign w_opaque = (rom_q != TRANSP_KEY);
`else
  assign w_opaque = 1'b1;
`endif

  assign rom_addr = r_addr;
  assign plot     = w_on && w_opaque;
  assign vga_x    = w_vld ? w_sx[VGA_X_W-1:0] : '0;
  assign vga_y    = w_vld ? w_sy[VGA_Y_W-1:0] : '0;
  assign colour   = w_vld ? rom_q : '0;
endmodule
